decode_stage: RTL and testbench

- Parametrised, pipelined MIPS decode stage; successor to the combinational decoder.
- Sits between the fetch stage (IF/ID) and the execute stage (ID/EX).
- Contains the register file and write-back bypass.
- Performs full immediate extension and jump-target formation.
- Registers all decoded fields into an ID/EX output register with valid/ready handshake, load-use stall and flush.

---
 rtl/decode_stage_if.sv | 47 ++++
 rtl/decode_stage.sv | 122 ++++++++++++
 tb/tb_decode_stage.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/decode_stage_if.sv
// Decode-stage port bundle: fetch-side request, write-back port, flush and the ID/EX result.
// The decoder uses the slave modport; the fetch/execute side (or a bench) uses master.
interface decode_stage_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
);
  localparam int RA = $clog2(NREGS);

  logic            in_valid;
  logic            in_ready;
  logic [31:0]     instr;
  logic [XLEN-1:0] pc_4;
  logic            wb_en;
  logic [RA-1:0]   wb_addr;
  logic [XLEN-1:0] wb_data;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [5:0]      out_opcode;
  logic [5:0]      out_funct;
  logic [4:0]      out_shamt;
  logic [RA-1:0]   out_rs;
  logic [RA-1:0]   out_rt;
  logic [RA-1:0]   out_rd;
  logic [XLEN-1:0] out_dato_a;
  logic [XLEN-1:0] out_dato_b;
  logic [XLEN-1:0] out_imm;
  logic            out_jump;
  logic [XLEN-1:0] out_jump_addr;
  logic            out_is_load;
  logic            branch_taken;
  logic [XLEN-1:0] branch_target;

  modport master (
    output in_valid, instr, pc_4, wb_en, wb_addr, wb_data, flush, out_ready,
    input  in_ready, out_valid, out_opcode, out_funct, out_shamt, out_rs, out_rt, out_rd,
           out_dato_a, out_dato_b, out_imm, out_jump, out_jump_addr, out_is_load,
           branch_taken, branch_target
  );

  modport slave (
    input  in_valid, instr, pc_4, wb_en, wb_addr, wb_data, flush, out_ready,
    output in_ready, out_valid, out_opcode, out_funct, out_shamt, out_rs, out_rt, out_rd,
           out_dato_a, out_dato_b, out_imm, out_jump, out_jump_addr, out_is_load,
           branch_taken, branch_target
  );
endinterface

// File: rtl/decode_stage.sv
// Pipelined MIPS decode stage: register file with write-back bypass, immediate/jump formation,
// ID/EX output register with load-use stall and flush. DECODE_BRANCH_CMP_EN adds early branch resolution.
module decode_stage #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input logic           clk,
  input logic           reset,
  decode_stage_if.slave bus
);
  localparam int RA = $clog2(NREGS);

  logic [5:0]      opcode;
  logic [RA-1:0]   rs, rt, rd;
  logic [XLEN-1:0] regs [NREGS];
  logic [XLEN-1:0] dato_a, dato_b;
  logic [XLEN-1:0] imm, imm_sext, jump_addr;
  logic            is_jump, uses_rt, hazard, accept;

  assign opcode   = bus.instr[31:26];
  assign rs       = RA'(bus.instr[25:21]);
  assign rt       = RA'(bus.instr[20:16]);
  assign rd       = RA'(bus.instr[15:11]);
  assign imm_sext = XLEN'($signed(bus.instr[15:0]));

  // Register 0 is hard-wired; a write-back in flight is forwarded to the captured operand.
  assign dato_a = (rs == '0) ? '0 : (bus.wb_en && bus.wb_addr == rs) ? bus.wb_data : regs[rs];
  assign dato_b = (rt == '0) ? '0 : (bus.wb_en && bus.wb_addr == rt) ? bus.wb_data : regs[rt];

  // NOTE: imm gets a default before the case so every path assigns it and no latch is inferred.
  always_comb begin
    imm = '0;
    case (opcode)
      6'h08, 6'h09, 6'h0A, 6'h23, 6'h2B, 6'h04, 6'h05: imm = imm_sext;
      6'h0C, 6'h0D, 6'h0E:                             imm = XLEN'(bus.instr[15:0]);
      6'h0F:                                           imm = XLEN'($signed({bus.instr[15:0], 16'h0000}));
      default:                                         imm = '0;
    endcase
  end

  assign is_jump   = (opcode == 6'h02) || (opcode == 6'h03);
  assign jump_addr = is_jump ? {bus.pc_4[XLEN-1:28], bus.instr[25:0], 2'b00} : '0;

  // A load in ID/EX blocks any consumer of its destination until it has moved on.
  assign uses_rt = opcode inside {6'h00, 6'h04, 6'h05, 6'h2B};
  assign hazard  = bus.out_valid && bus.out_is_load && (bus.out_rt != '0) &&
                   ((bus.out_rt == rs) || (uses_rt && bus.out_rt == rt));

  assign bus.in_ready = (!bus.out_valid || bus.out_ready) && !hazard;
  assign accept       = bus.in_valid && bus.in_ready;

  // NOTE: the register file is in the reset domain so every register reads 0 after reset; it maps to flops, not RAM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (bus.wb_en && bus.wb_addr != '0) begin
      regs[bus.wb_addr] <= bus.wb_data;
    end
  end

  // NOTE: non-blocking assignments so every ID/EX field samples the pre-edge operands and handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.out_valid     <= 1'b0;
      bus.out_opcode    <= '0;
      bus.out_funct     <= '0;
      bus.out_shamt     <= '0;
      bus.out_rs        <= '0;
      bus.out_rt        <= '0;
      bus.out_rd        <= '0;
      bus.out_dato_a    <= '0;
      bus.out_dato_b    <= '0;
      bus.out_imm       <= '0;
      bus.out_jump      <= 1'b0;
      bus.out_jump_addr <= '0;
      bus.out_is_load   <= 1'b0;
    end else if (bus.flush) begin
      bus.out_valid <= 1'b0;
    end else if (accept) begin
      bus.out_valid     <= 1'b1;
      bus.out_opcode    <= opcode;
      bus.out_funct     <= bus.instr[5:0];
      bus.out_shamt     <= bus.instr[10:6];
      bus.out_rs        <= rs;
      bus.out_rt        <= rt;
      bus.out_rd        <= rd;
      bus.out_dato_a    <= dato_a;
      bus.out_dato_b    <= dato_b;
      bus.out_imm       <= imm;
      bus.out_jump      <= is_jump;
      bus.out_jump_addr <= jump_addr;
      bus.out_is_load   <= (opcode == 6'h23);
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end

`ifdef DECODE_BRANCH_CMP_EN
  logic            br_taken_next;
  logic [XLEN-1:0] br_target_next;

  assign br_taken_next  = ((opcode == 6'h04) && (dato_a == dato_b)) ||
                          ((opcode == 6'h05) && (dato_a != dato_b));
  assign br_target_next = bus.pc_4 + (imm_sext << 2);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.branch_taken  <= 1'b0;
      bus.branch_target <= '0;
    end else if (!bus.flush && accept) begin
      bus.branch_taken  <= br_taken_next;
      bus.branch_target <= br_target_next;
    end
  end
`else
  logic unused_pc_low;

  assign bus.branch_taken  = 1'b0;
  assign bus.branch_target = '0;
  assign unused_pc_low     = ^bus.pc_4[27:0];
`endif
endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed test-plan cases plus random traffic; a driver-side model
// pushes expected ID/EX records into a scoreboard that an independent monitor pops and compares.
module tb_decode_stage;
  typedef struct packed {
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  shamt;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic        jump;
    logic [31:0] jaddr;
    logic        is_load;
    logic        br_taken;
    logic [31:0] br_target;
  } idex_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  decode_stage_if #(.XLEN(32), .NREGS(32)) bus ();
  decode_stage #(.XLEN(32), .NREGS(32)) dut (.clk(clk), .reset(reset), .bus(bus));

  int          n_cmp  = 0;
  int          n_fail = 0;
  idex_t       sb[$];
  logic [31:0] model_regs [32];
  idex_t       slot;
  logic        slot_v = 1'b0;

  task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic idex_t dut_out();
    idex_t r;
    r.opcode    = bus.out_opcode;
    r.funct     = bus.out_funct;
    r.shamt     = bus.out_shamt;
    r.rs        = bus.out_rs;
    r.rt        = bus.out_rt;
    r.rd        = bus.out_rd;
    r.a         = bus.out_dato_a;
    r.b         = bus.out_dato_b;
    r.imm       = bus.out_imm;
    r.jump      = bus.out_jump;
    r.jaddr     = bus.out_jump_addr;
    r.is_load   = bus.out_is_load;
    r.br_taken  = bus.branch_taken;
    r.br_target = bus.branch_target;
    return r;
  endfunction

  function automatic logic [31:0] operand(input logic [4:0] r, input logic we,
                                          input logic [4:0] wa, input logic [31:0] wd);
    if (r == 0) return 32'd0;
    if (we && wa == r) return wd;
    return model_regs[r];
  endfunction

  // Reference decode written from the instruction-set rules with plain arithmetic.
  function automatic idex_t model_decode(input logic [31:0] ins, input logic [31:0] pc4,
                                         input logic [31:0] a, input logic [31:0] b);
    idex_t       e;
    int          v;
    logic [31:0] imm_s;
    logic [5:0]  op;
    op = ins[31:26];
    v  = int'(ins[15:0]);
    if (ins[15]) v = v - 65536;
    imm_s = 32'(v);
    e.opcode = op;
    e.funct  = ins[5:0];
    e.shamt  = ins[10:6];
    e.rs     = ins[25:21];
    e.rt     = ins[20:16];
    e.rd     = ins[15:11];
    e.a      = a;
    e.b      = b;
    case (op)
      6'h08, 6'h09, 6'h0A, 6'h23, 6'h2B, 6'h04, 6'h05: e.imm = imm_s;
      6'h0C, 6'h0D, 6'h0E: e.imm = 32'(ins[15:0]);
      6'h0F:               e.imm = 32'(ins[15:0]) * 32'd65536;
      default:             e.imm = 32'd0;
    endcase
    e.jump    = (op == 6'h02) || (op == 6'h03);
    e.jaddr   = e.jump ? (pc4 & 32'hF000_0000) + 32'(ins[25:0]) * 32'd4 : 32'd0;
    e.is_load = (op == 6'h23);
`ifdef DECODE_BRANCH_CMP_EN
    e.br_taken  = ((op == 6'h04) && (a == b)) || ((op == 6'h05) && (a != b));
    e.br_target = pc4 + imm_s * 32'd4;
`else
    e.br_taken  = 1'b0;
    e.br_target = 32'd0;
`endif
    return e;
  endfunction

  // One clock of stimulus; checks out_valid and in_ready against the model, pushes on accept.
  task automatic cycle(input logic iv, input logic [31:0] ins, input logic [31:0] pc,
                       input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic fl, input logic ordy, output logic rdy_seen);
    logic       haz, exp_rdy, acc, uses_rt;
    logic [5:0] op;
    @(negedge clk);
    bus.in_valid  = iv;
    bus.instr     = ins;
    bus.pc_4      = pc;
    bus.wb_en     = we;
    bus.wb_addr   = wa;
    bus.wb_data   = wd;
    bus.flush     = fl;
    bus.out_ready = ordy;
    #1;
    op      = ins[31:26];
    uses_rt = (op == 6'h00) || (op == 6'h04) || (op == 6'h05) || (op == 6'h2B);
    haz     = slot_v && slot.is_load && (slot.rt != 0) &&
              ((slot.rt == ins[25:21]) || (uses_rt && slot.rt == ins[20:16]));
    exp_rdy = (!slot_v || ordy) && !haz;
    rdy_seen = bus.in_ready;
    check("out_valid", 256'(bus.out_valid), 256'(slot_v));
    if (!fl) check("in_ready", 256'(bus.in_ready), 256'(exp_rdy));
    acc = iv && exp_rdy && !fl;
    if (fl) begin
      slot_v = 1'b0;
    end else if (acc) begin
      slot = model_decode(ins, pc, operand(ins[25:21], we, wa, wd), operand(ins[20:16], we, wa, wd));
      sb.push_back(slot);
      slot_v = 1'b1;
    end else if (ordy) begin
      slot_v = 1'b0;
    end
    @(posedge clk);
    if (we && wa != 0) model_regs[wa] = wd;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.wb_en    = 1'b0;
    bus.flush    = 1'b0;
    #1;
    check("reset_valid", 256'(bus.out_valid), 256'(0));
    check("reset_fields", 256'(dut_out()), 256'(0));
    for (int i = 0; i < 32; i++) model_regs[i] = 32'd0;
    sb.delete();
    slot_v = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Monitor: compares the ID/EX contents against the scoreboard head on every valid cycle.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!reset && bus.out_valid) begin
        if (sb.size() == 0) begin
          check("scoreboard_empty", 256'(1), 256'(0));
        end else begin
          check("id_ex", 256'(dut_out()), 256'(sb[0]));
          if (bus.flush || bus.out_ready) void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic        rdy;
    logic [5:0]  ops [16];
    logic [31:0] ins;
    ops = '{6'h00, 6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09,
            6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B, 6'h1F};
    bus.in_valid  = 1'b0;
    bus.instr     = 32'd0;
    bus.pc_4      = 32'd0;
    bus.wb_en     = 1'b0;
    bus.wb_addr   = 5'd0;
    bus.wb_data   = 32'd0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    apply_reset();

    cycle(1'b1, 32'h2001FFFB, 32'h4, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1, rdy);
    #1;
    check("addi_valid", 256'(bus.out_valid), 256'(1));
    check("addi_imm", 256'(bus.out_imm), 256'(32'hFFFFFFFB));
    check("addi_rs", 256'(bus.out_rs), 256'(0));
    check("addi_rt", 256'(bus.out_rt), 256'(1));

    cycle(1'b1, 32'h34028001, 32'h8, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1, rdy);
    #1 check("ori_imm", 256'(bus.out_imm), 256'(32'h00008001));
    cycle(1'b1, 32'h3C031234, 32'hC, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1, rdy);
    #1 check("lui_imm", 256'(bus.out_imm), 256'(32'h12340000));
    cycle(1'b1, 32'h08100000, 32'hA0000004, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1, rdy);
    #1;
    check("j_jump", 256'(bus.out_jump), 256'(1));
    check("j_addr", 256'(bus.out_jump_addr), 256'(32'hA0400000));

    cycle(1'b1, 32'h00A03020, 32'h10, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 1'b1, rdy);
    #1;
    check("bypass_a", 256'(bus.out_dato_a), 256'(32'hDEADBEEF));
    check("bypass_b", 256'(bus.out_dato_b), 256'(0));
    cycle(1'b1, 32'h00053020, 32'h14, 1'b1, 5'd0, 32'h12345678, 1'b0, 1'b1, rdy);
    #1;
    check("r0_read", 256'(bus.out_dato_a), 256'(0));
    check("r5_read", 256'(bus.out_dato_b), 256'(32'hDEADBEEF));

    cycle(1'b1, 32'h8C240000, 32'h18, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1, rdy);
    cycle(1'b1, 32'h00843820, 32'h1C, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1, rdy);
    check("loaduse_stall", 256'(rdy), 256'(0));
    #1 check("loaduse_bubble", 256'(bus.out_valid), 256'(0));
    cycle(1'b1, 32'h00843820, 32'h1C, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1, rdy);
    #1 check("loaduse_issue_rd", 256'(bus.out_rd), 256'(7));
    for (int i = 0; i < 2; i++) begin
      cycle(1'b1, 32'h34028001, 32'h20, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, rdy);
      #1;
      check("hold_valid", 256'(bus.out_valid), 256'(1));
      check("hold_rd", 256'(bus.out_rd), 256'(7));
    end
    cycle(1'b1, 32'h34028001, 32'h20, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, rdy);
    #1 check("flush_valid", 256'(bus.out_valid), 256'(0));

    cycle(1'b1, 32'h10210004, 32'h100, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1, rdy);
    #1;
`ifdef DECODE_BRANCH_CMP_EN
    check("beq_taken", 256'(bus.branch_taken), 256'(1));
    check("beq_target", 256'(bus.branch_target), 256'(32'h110));
`else
    check("beq_taken_off", 256'(bus.branch_taken), 256'(0));
    check("beq_target_off", 256'(bus.branch_target), 256'(0));
`endif

    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 2000; i++) begin
        ins = {ops[$urandom_range(0, 15)], 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
               16'($urandom)};
        cycle(($urandom_range(0, 3) != 0), ins, $urandom, 1'($urandom_range(0, 1)),
              5'($urandom_range(0, 7)), $urandom, ($urandom_range(0, 31) == 0),
              ($urandom_range(0, 3) != 0), rdy);
      end
      if (pass == 0) begin
        cycle(1'b1, 32'h2001FFFB, 32'h4, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, rdy);
        apply_reset();
      end
    end

    for (int i = 0; i < 3; i++) cycle(1'b0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1, rdy);
    check("scoreboard_drained", 256'(sb.size()), 256'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
